// File: rtl/c2h_byp_pkg.sv
// Shared types and constants for the C2H descriptor-bypass router.
// Latency: n/a (types only).
// Backpressure: n/a. The qid width is fixed here because it sizes the packed structs.
package c2h_byp_pkg;

  localparam int QID_W  = 11;
  localparam int FUNC_W = 8;
  localparam int CIDX_W = 16;
  localparam int PORT_W = 3;
  localparam int LEN_W  = 28;

  // Bit positions inside the 256-bit bypass descriptor
  localparam int ADDR_LSB = 0;
  localparam int LEN_LSB  = 64;
  localparam int SDI_BIT  = 94;
  localparam int WADR_LSB = 128;

  typedef enum logic [1:0] {
    BYP_NONE = 2'b00,
    BYP_CSH  = 2'b01,
    BYP_SIM  = 2'b10
  } byp_mode_e;

  typedef enum logic [1:0] {
    FENCE_IDLE,
    FENCE_DRAIN,
    FENCE_RESP
  } fence_state_e;

  typedef struct packed {
    logic [255:0]       dsc;
    logic               mrkr_rsp;
    logic               st_mm;
    logic [1:0]         dsc_sz;
    logic [QID_W-1:0]   qid;
    logic               error;
    logic [FUNC_W-1:0]  func;
    logic [CIDX_W-1:0]  cidx;
    logic [PORT_W-1:0]  port_id;
  } c2h_byp_out_t;

  typedef struct packed {
    logic [63:0]        radr;
    logic [63:0]        wadr;
    logic [LEN_W-1:0]   len;
    logic               mrkr_req;
    logic               sdi;
    logic [QID_W-1:0]   qid;
    logic               error;
    logic [FUNC_W-1:0]  func;
    logic [CIDX_W-1:0]  cidx;
    logic [PORT_W-1:0]  port_id;
    logic               no_dma;
  } c2h_byp_mm_t;

  typedef struct packed {
    logic [63:0]        addr;
    logic [QID_W-1:0]   qid;
    logic               error;
    logic [FUNC_W-1:0]  func;
    logic [PORT_W-1:0]  port_id;
  } c2h_byp_st_t;

endpackage

// File: rtl/c2h_byp_fifo.sv
// First-word-fall-through FIFO of DEPTH entries of type T, with full/empty flags.
// Latency: a push in cycle N is visible on dout with empty=0 in N+1.
// Backpressure: push ignored when full, pop ignored when empty; a pop frees space only from the next cycle.
module c2h_byp_fifo #(
  parameter int  DEPTH = 4,
  parameter type T     = logic
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  T     din,
  input  logic pop,
  output T     dout,
  output logic full,
  output logic empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  T              mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] cnt;
  logic          wr_en;
  logic          rd_en;

  assign wr_en = push & ~full;
  assign rd_en = pop & ~empty;

  // Storage array; contents are don't-care until written, so no reset
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= din;
  end

  // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PW'(1);
      if (rd_en) rd_ptr <= rd_ptr + PW'(1);
      case ({wr_en, rd_en})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  assign full  = (cnt == CW'(DEPTH));
  assign empty = (cnt == '0);
  assign dout  = mem[rd_ptr];

endmodule

// File: rtl/c2h_dsc_byp_router.sv
// Steers C2H bypass-out descriptors into MM / ST-cache / ST-simple FIFOs; markers fence their path.
// Latency: accepted in N -> path vld in N+1; marker response earliest N+2, next accept N+3.
// Backpressure: byp_out_rdy low when target FIFO full or a marker is draining. Stats: C2H_BYP_STATS_EN.
module c2h_dsc_byp_router
  import c2h_byp_pkg::*;
#(
  parameter int DEPTH = 4
`ifdef C2H_BYP_STATS_EN
  , parameter int CNT_W = 32
`endif
) (
  input  logic         axi_aclk,
  input  logic         axi_aresetn,
  input  logic [1:0]   c2h_dsc_bypass,
  input  logic         c2h_mm_marker_req,
  input  c2h_byp_out_t byp_out,
  input  logic         byp_out_vld,
  output logic         byp_out_rdy,
  output c2h_byp_mm_t  mm_out,
  output logic         mm_vld,
  input  logic         mm_rdy,
  output c2h_byp_st_t  csh_out,
  output logic         csh_vld,
  input  logic         csh_rdy,
  output c2h_byp_st_t  sim_out,
  output logic         sim_vld,
  input  logic         sim_rdy,
  output logic         c2h_mm_marker_rsp,
  output logic         c2h_st_marker_rsp
`ifdef C2H_BYP_STATS_EN
  , output logic [CNT_W-1:0] cnt_mm
  , output logic [CNT_W-1:0] cnt_csh
  , output logic [CNT_W-1:0] cnt_sim
  , output logic [CNT_W-1:0] cnt_drop
`endif
);

  fence_state_e state_q, state_d;
  logic         mrk_st_mm_q;
  logic         is_mrk, mode_csh, mode_sim;
  logic         cls_mm, cls_csh, cls_sim, cls_drop, space_ok, acc;
  logic         push_mm, push_csh, push_sim, drain_done;
  logic         mm_full, mm_empty, csh_full, csh_empty, sim_full, sim_empty;
  c2h_byp_mm_t  mm_din, mm_dout;
  c2h_byp_st_t  st_din, csh_dout, sim_dout;
  logic         unused_bits;

  // Only some descriptor bits feed the output formats
  assign unused_bits = ^{byp_out.dsc, byp_out.dsc_sz};

  // Classify the presented beat and decide whether it can be taken this cycle
  always_comb begin
    is_mrk   = byp_out.mrkr_rsp;
    mode_csh = (c2h_dsc_bypass == BYP_CSH);
    mode_sim = (c2h_dsc_bypass == BYP_SIM);
    cls_mm   = ~is_mrk & (mode_csh | mode_sim) & byp_out.st_mm;
    cls_csh  = ~is_mrk & mode_csh & ~byp_out.st_mm;
    cls_sim  = ~is_mrk & mode_sim & ~byp_out.st_mm;
    cls_drop = ~is_mrk & ~(cls_mm | cls_csh | cls_sim);
    space_ok = is_mrk | cls_drop | (cls_mm & ~mm_full)
             | (cls_csh & ~csh_full) | (cls_sim & ~sim_full);
  end

  assign byp_out_rdy = (state_q == FENCE_IDLE) & space_ok;
  assign acc         = byp_out_vld & byp_out_rdy;
  assign push_mm     = acc & cls_mm;
  assign push_csh    = acc & cls_csh;
  assign push_sim    = acc & cls_sim;

  // Reformat the descriptor into the MM and ST bypass-in layouts
  always_comb begin
    mm_din          = '0;
    mm_din.radr     = byp_out.dsc[ADDR_LSB +: 64];
    mm_din.wadr     = byp_out.dsc[WADR_LSB +: 64];
    mm_din.len      = byp_out.dsc[LEN_LSB +: LEN_W];
    mm_din.sdi      = byp_out.dsc[SDI_BIT];
    mm_din.qid      = byp_out.qid;
    mm_din.error    = byp_out.error;
    mm_din.func     = byp_out.func;
    mm_din.cidx     = byp_out.cidx;
    mm_din.port_id  = byp_out.port_id;
    st_din          = '0;
    st_din.addr     = byp_out.dsc[ADDR_LSB +: 64];
    st_din.qid      = byp_out.qid;
    st_din.error    = byp_out.error;
    st_din.func     = byp_out.func;
    st_din.port_id  = byp_out.port_id;
  end

  c2h_byp_fifo #(.DEPTH(DEPTH), .T(c2h_byp_mm_t)) u_mm_fifo (
    .clk(axi_aclk), .rst_n(axi_aresetn), .push(push_mm), .din(mm_din),
    .pop(mm_vld & mm_rdy), .dout(mm_dout), .full(mm_full), .empty(mm_empty));

  c2h_byp_fifo #(.DEPTH(DEPTH), .T(c2h_byp_st_t)) u_csh_fifo (
    .clk(axi_aclk), .rst_n(axi_aresetn), .push(push_csh), .din(st_din),
    .pop(csh_vld & csh_rdy), .dout(csh_dout), .full(csh_full), .empty(csh_empty));

  c2h_byp_fifo #(.DEPTH(DEPTH), .T(c2h_byp_st_t)) u_sim_fifo (
    .clk(axi_aclk), .rst_n(axi_aresetn), .push(push_sim), .din(st_din),
    .pop(sim_vld & sim_rdy), .dout(sim_dout), .full(sim_full), .empty(sim_empty));

  assign mm_vld  = ~mm_empty;
  assign csh_vld = ~csh_empty;
  assign sim_vld = ~sim_empty;
  assign csh_out = csh_dout;
  assign sim_out = sim_dout;

  // MM marker request is not queued; it rides alongside the FIFO head
  always_comb begin
    mm_out          = mm_dout;
    mm_out.mrkr_req = c2h_mm_marker_req;
  end

  // Fence state register; the marker's ST/MM flag selects which path it waits on
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      state_q     <= FENCE_IDLE;
      mrk_st_mm_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (acc & is_mrk) mrk_st_mm_q <= byp_out.st_mm;
    end
  end

  // Fence next state: hold intake until the fenced path(s) have fully drained
  always_comb begin
    state_d    = state_q;
    drain_done = mrk_st_mm_q ? mm_empty : (csh_empty & sim_empty);
    case (state_q)
      FENCE_IDLE:  if (acc & is_mrk) state_d = FENCE_DRAIN;
      FENCE_DRAIN: if (drain_done) state_d = FENCE_RESP;
      FENCE_RESP:  state_d = FENCE_IDLE;
      default:     state_d = FENCE_IDLE;
    endcase
  end

  assign c2h_mm_marker_rsp = (state_q == FENCE_RESP) &  mrk_st_mm_q;
  assign c2h_st_marker_rsp = (state_q == FENCE_RESP) & ~mrk_st_mm_q;

`ifdef C2H_BYP_STATS_EN
  // Saturating per-class counters of accepted descriptors; markers are not counted
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      cnt_mm   <= '0;
      cnt_csh  <= '0;
      cnt_sim  <= '0;
      cnt_drop <= '0;
    end else begin
      if (push_mm  && cnt_mm  != '1) cnt_mm  <= cnt_mm  + CNT_W'(1);
      if (push_csh && cnt_csh != '1) cnt_csh <= cnt_csh + CNT_W'(1);
      if (push_sim && cnt_sim != '1) cnt_sim <= cnt_sim + CNT_W'(1);
      if (acc && cls_drop && cnt_drop != '1) cnt_drop <= cnt_drop + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_c2h_dsc_byp_router.sv
// Self-checking bench for c2h_dsc_byp_router: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
// Counter checks are active when C2H_BYP_STATS_EN is defined.
module tb_c2h_dsc_byp_router;
  import c2h_byp_pkg::*;

  localparam int DEPTH = 4;

  logic         axi_aclk = 1'b0;
  logic         axi_aresetn;
  logic [1:0]   c2h_dsc_bypass;
  logic         c2h_mm_marker_req;
  c2h_byp_out_t byp_out;
  logic         byp_out_vld, byp_out_rdy;
  c2h_byp_mm_t  mm_out;
  logic         mm_vld, mm_rdy;
  c2h_byp_st_t  csh_out, sim_out;
  logic         csh_vld, csh_rdy, sim_vld, sim_rdy;
  logic         c2h_mm_marker_rsp, c2h_st_marker_rsp;
`ifdef C2H_BYP_STATS_EN
  logic [31:0]  cnt_mm, cnt_csh, cnt_sim, cnt_drop;
  int           m_cnt_mm, m_cnt_csh, m_cnt_sim, m_cnt_drop;
`endif

  always #5 axi_aclk = ~axi_aclk;

  c2h_dsc_byp_router #(.DEPTH(DEPTH)) dut (
    .axi_aclk(axi_aclk), .axi_aresetn(axi_aresetn),
    .c2h_dsc_bypass(c2h_dsc_bypass), .c2h_mm_marker_req(c2h_mm_marker_req),
    .byp_out(byp_out), .byp_out_vld(byp_out_vld), .byp_out_rdy(byp_out_rdy),
    .mm_out(mm_out), .mm_vld(mm_vld), .mm_rdy(mm_rdy),
    .csh_out(csh_out), .csh_vld(csh_vld), .csh_rdy(csh_rdy),
    .sim_out(sim_out), .sim_vld(sim_vld), .sim_rdy(sim_rdy),
    .c2h_mm_marker_rsp(c2h_mm_marker_rsp), .c2h_st_marker_rsp(c2h_st_marker_rsp)
`ifdef C2H_BYP_STATS_EN
    , .cnt_mm(cnt_mm), .cnt_csh(cnt_csh), .cnt_sim(cnt_sim), .cnt_drop(cnt_drop)
`endif
  );

  // Reference model: what each path must hold, and the marker fence
  c2h_byp_mm_t q_mm[$];
  c2h_byp_st_t q_csh[$];
  c2h_byp_st_t q_sim[$];
  bit          blocked, resp_now, fence_st;

  int n_checks = 0, n_errors = 0, cyc = 0;
  int n_mm_pop = 0, n_csh_pop = 0, n_sim_pop = 0, last_mm_pop = 0;
  int n_mm_pulse = 0, n_st_pulse = 0, mm_pulse_cyc = 0, st_pulse_cyc = 0;
  int acc_cyc = 0;
  bit last_acc;
  c2h_byp_st_t first_csh;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s @cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic c2h_byp_mm_t exp_mm(input c2h_byp_out_t b);
    c2h_byp_mm_t m;
    m = '0;
    m.radr = b.dsc[63:0];
    m.wadr = b.dsc[191:128];
    m.len = b.dsc[91:64];
    m.sdi = b.dsc[94];
    m.qid = b.qid; m.error = b.error; m.func = b.func; m.cidx = b.cidx;
    m.port_id = b.port_id;
    m.no_dma = 1'b0;
    return m;
  endfunction

  function automatic c2h_byp_st_t exp_st(input c2h_byp_out_t b);
    c2h_byp_st_t s;
    s.addr = b.dsc[63:0];
    s.qid = b.qid; s.error = b.error; s.func = b.func; s.port_id = b.port_id;
    return s;
  endfunction

  function automatic c2h_byp_out_t mk_beat(input logic [63:0] addr, input bit mrk, input bit st_mm);
    c2h_byp_out_t b;
    for (int i = 0; i < 8; i++) b.dsc[i*32 +: 32] = $urandom();
    b.dsc[63:0] = addr;
    b.mrkr_rsp = mrk;
    b.st_mm = st_mm;
    b.dsc_sz = 2'($urandom());
    b.qid = 11'($urandom());
    b.error = 1'($urandom());
    b.func = 8'($urandom());
    b.cidx = 16'($urandom());
    b.port_id = 3'($urandom());
    return b;
  endfunction

  // One cycle: compare DUT against the model, then advance the model over the coming edge
  task automatic step();
    int cur;
    bit is_mrk, md_csh, md_sim, to_mm, to_csh, to_sim, to_drop, exp_rdy, acc, tgt_empty;
    c2h_byp_mm_t em;
    cur = cyc;
    #1;
    last_acc = 1'b0;
    if (!axi_aresetn) begin
      check("rst_mm_vld", 256'(mm_vld), 256'(0));
      check("rst_csh_vld", 256'(csh_vld), 256'(0));
      check("rst_sim_vld", 256'(sim_vld), 256'(0));
      check("rst_mm_rsp", 256'(c2h_mm_marker_rsp), 256'(0));
      check("rst_st_rsp", 256'(c2h_st_marker_rsp), 256'(0));
      q_mm.delete(); q_csh.delete(); q_sim.delete();
      blocked = 0; resp_now = 0; fence_st = 0;
`ifdef C2H_BYP_STATS_EN
      m_cnt_mm = 0; m_cnt_csh = 0; m_cnt_sim = 0; m_cnt_drop = 0;
`endif
    end else begin
      is_mrk  = byp_out.mrkr_rsp;
      md_csh  = (c2h_dsc_bypass == 2'b01);
      md_sim  = (c2h_dsc_bypass == 2'b10);
      to_mm   = !is_mrk && (md_csh || md_sim) && byp_out.st_mm;
      to_csh  = !is_mrk && md_csh && !byp_out.st_mm;
      to_sim  = !is_mrk && md_sim && !byp_out.st_mm;
      to_drop = !is_mrk && !to_mm && !to_csh && !to_sim;
      exp_rdy = !blocked && (is_mrk || to_drop || (to_mm && q_mm.size() < DEPTH)
                || (to_csh && q_csh.size() < DEPTH) || (to_sim && q_sim.size() < DEPTH));
      check("byp_out_rdy", 256'(byp_out_rdy), 256'(exp_rdy));
      check("mm_vld", 256'(mm_vld), 256'(q_mm.size() != 0));
      check("csh_vld", 256'(csh_vld), 256'(q_csh.size() != 0));
      check("sim_vld", 256'(sim_vld), 256'(q_sim.size() != 0));
      check("mm_mrkr_req", 256'(mm_out.mrkr_req), 256'(c2h_mm_marker_req));
      if (q_mm.size() != 0 && mm_vld) begin
        em = q_mm[0];
        em.mrkr_req = c2h_mm_marker_req;
        check("mm_out", 256'(mm_out), 256'(em));
      end
      if (q_csh.size() != 0 && csh_vld) check("csh_out", 256'(csh_out), 256'(q_csh[0]));
      if (q_sim.size() != 0 && sim_vld) check("sim_out", 256'(sim_out), 256'(q_sim[0]));
      check("mm_marker_rsp", 256'(c2h_mm_marker_rsp), 256'(resp_now && fence_st));
      check("st_marker_rsp", 256'(c2h_st_marker_rsp), 256'(resp_now && !fence_st));
`ifdef C2H_BYP_STATS_EN
      check("cnt_mm", 256'(cnt_mm), 256'(m_cnt_mm));
      check("cnt_csh", 256'(cnt_csh), 256'(m_cnt_csh));
      check("cnt_sim", 256'(cnt_sim), 256'(m_cnt_sim));
      check("cnt_drop", 256'(cnt_drop), 256'(m_cnt_drop));
`endif
      // What the DUT actually did this cycle, for the directed scenarios
      if (mm_vld && mm_rdy) begin n_mm_pop++; last_mm_pop = cur; end
      if (csh_vld && csh_rdy) begin
        if (n_csh_pop == 0) first_csh = csh_out;
        n_csh_pop++;
      end
      if (sim_vld && sim_rdy) n_sim_pop++;
      if (c2h_mm_marker_rsp) begin n_mm_pulse++; mm_pulse_cyc = cur; end
      if (c2h_st_marker_rsp) begin n_st_pulse++; st_pulse_cyc = cur; end
      last_acc = byp_out_vld && byp_out_rdy;
      if (last_acc) acc_cyc = cur;
      // Model advance: a marker answers the cycle after its path is seen empty
      acc = byp_out_vld && exp_rdy;
      tgt_empty = fence_st ? (q_mm.size() == 0) : (q_csh.size() == 0 && q_sim.size() == 0);
      if (resp_now) begin
        resp_now = 0;
        blocked = 0;
      end else if (blocked && tgt_empty) begin
        resp_now = 1;
      end
      if (q_mm.size() != 0 && mm_rdy) void'(q_mm.pop_front());
      if (q_csh.size() != 0 && csh_rdy) void'(q_csh.pop_front());
      if (q_sim.size() != 0 && sim_rdy) void'(q_sim.pop_front());
      if (acc) begin
        if (is_mrk) begin
          blocked = 1;
          fence_st = byp_out.st_mm;
        end
        if (to_mm) q_mm.push_back(exp_mm(byp_out));
        if (to_csh) q_csh.push_back(exp_st(byp_out));
        if (to_sim) q_sim.push_back(exp_st(byp_out));
`ifdef C2H_BYP_STATS_EN
        if (to_mm) m_cnt_mm++;
        if (to_csh) m_cnt_csh++;
        if (to_sim) m_cnt_sim++;
        if (to_drop) m_cnt_drop++;
`endif
      end
    end
    @(negedge axi_aclk);
    cyc++;
  endtask

  task automatic send(input c2h_byp_out_t b, input logic [1:0] mode, input int bound, output bit ok);
    byp_out = b;
    c2h_dsc_bypass = mode;
    byp_out_vld = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      step();
      if (last_acc) begin ok = 1'b1; break; end
    end
    byp_out_vld = 1'b0;
  endtask

  task automatic idle(input int n);
    byp_out_vld = 1'b0;
    repeat (n) step();
  endtask

  initial begin
    bit ok;
    int n_ok, base, base2, rel, n_acc;
`ifdef C2H_BYP_STATS_EN
    int base_drop;
`endif
    axi_aresetn = 1'b0;
    c2h_dsc_bypass = 2'b00;
    c2h_mm_marker_req = 1'b0;
    byp_out = '0;
    byp_out_vld = 1'b0;
    mm_rdy = 1'b1; csh_rdy = 1'b1; sim_rdy = 1'b1;
    @(negedge axi_aclk);
    repeat (3) step();
    axi_aresetn = 1'b1;
    #1;
    check("rdy_after_reset", 256'(byp_out_rdy), 256'(1));

    // Mode 01: three ST beats to the cache path, two MM beats
    send(mk_beat(64'h1000, 0, 0), 2'b01, 4, ok); check("t1_acc0", 256'(ok), 256'(1));
    send(mk_beat(64'h1100, 0, 0), 2'b01, 4, ok); check("t1_acc1", 256'(ok), 256'(1));
    send(mk_beat(64'h1200, 0, 0), 2'b01, 4, ok); check("t1_acc2", 256'(ok), 256'(1));
    send(mk_beat(64'h2000, 0, 1), 2'b01, 4, ok); check("t1_acc3", 256'(ok), 256'(1));
    send(mk_beat(64'h2100, 0, 1), 2'b01, 4, ok); check("t1_acc4", 256'(ok), 256'(1));
    idle(4);
    check("t1_csh_count", 256'(n_csh_pop), 256'(3));
    check("t1_mm_count", 256'(n_mm_pop), 256'(2));
    check("t1_first_csh_addr", 256'(first_csh.addr), 256'(64'h1000));

    // Mode 10 with a stalled sink: only DEPTH beats fit, a pop frees space a cycle later
    sim_rdy = 1'b0;
    n_ok = 0;
    for (int i = 0; i < 5; i++) begin
      send(mk_beat(64'h3000 + 64'(i), 0, 0), 2'b10, 6, ok);
      if (ok) n_ok++;
    end
    check("t2_accepted", 256'(n_ok), 256'(4));
    byp_out = mk_beat(64'h3004, 0, 0);
    byp_out_vld = 1'b1;
    sim_rdy = 1'b1;
    rel = cyc;
    ok = 1'b0;
    for (int i = 0; i < 6 && !ok; i++) begin
      step();
      ok = last_acc;
    end
    byp_out_vld = 1'b0;
    check("t2_fifth_after_pop", 256'(acc_cyc - rel), 256'(1));
    idle(8);

    // MM marker held behind two stalled MM descriptors
    mm_rdy = 1'b0;
    send(mk_beat(64'h4000, 0, 1), 2'b01, 4, ok); check("t3_acc0", 256'(ok), 256'(1));
    send(mk_beat(64'h4100, 0, 1), 2'b01, 4, ok); check("t3_acc1", 256'(ok), 256'(1));
    send(mk_beat(64'h0, 1, 1), 2'b01, 4, ok);    check("t3_mrk_acc", 256'(ok), 256'(1));
    base = n_mm_pulse;
    idle(5);
    check("t3_no_rsp_yet", 256'(n_mm_pulse - base), 256'(0));
    mm_rdy = 1'b1;
    idle(6);
    check("t3_one_rsp", 256'(n_mm_pulse - base), 256'(1));
    check("t3_rsp_after_pop", 256'(mm_pulse_cyc - last_mm_pop), 256'(2));

    // Mode 00: every beat accepted back to back and discarded
`ifdef C2H_BYP_STATS_EN
    base_drop = int'(cnt_drop);
`endif
    base = n_csh_pop + n_sim_pop + n_mm_pop;
    n_acc = 0;
    c2h_dsc_bypass = 2'b00;
    for (int i = 0; i < 6; i++) begin
      byp_out = mk_beat(64'h5000 + 64'(i), 0, 0);
      byp_out_vld = 1'b1;
      step();
      if (last_acc) n_acc++;
    end
    byp_out_vld = 1'b0;
    idle(3);
    check("t4_drop_accepted", 256'(n_acc), 256'(6));
    check("t4_no_output", 256'(n_csh_pop + n_sim_pop + n_mm_pop - base), 256'(0));
`ifdef C2H_BYP_STATS_EN
    check("t4_cnt_drop", 256'(int'(cnt_drop) - base_drop), 256'(6));
`endif

    // ST marker with empty FIFOs: pulse at N+2, next beat at N+3
    base = n_st_pulse;
    send(mk_beat(64'h0, 1, 0), 2'b01, 4, ok);
    check("t5_mrk_acc", 256'(ok), 256'(1));
    rel = acc_cyc;
    send(mk_beat(64'h6000, 0, 0), 2'b01, 8, ok);
    check("t5_next_acc", 256'(ok), 256'(1));
    check("t5_pulse_count", 256'(n_st_pulse - base), 256'(1));
    check("t5_pulse_cycle", 256'(st_pulse_cyc - rel), 256'(2));
    check("t5_next_cycle", 256'(acc_cyc - rel), 256'(3));
    idle(4);

    // Reset while a marker is draining: no pulse, queued entries discarded
    csh_rdy = 1'b0;
    send(mk_beat(64'h7000, 0, 0), 2'b01, 4, ok);
    send(mk_beat(64'h7100, 0, 0), 2'b01, 4, ok);
    send(mk_beat(64'h0, 1, 0), 2'b01, 4, ok);
    idle(2);
    base = n_st_pulse;
    base2 = n_csh_pop;
    axi_aresetn = 1'b0;
    step();
    step();
    axi_aresetn = 1'b1;
    csh_rdy = 1'b1;
    idle(6);
    check("t6_no_pulse", 256'(n_st_pulse - base), 256'(0));
    check("t6_fifo_empty", 256'(n_csh_pop - base2), 256'(0));

    // Randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      byp_out = mk_beat({$urandom(), $urandom()}, ($urandom_range(11) == 0), 1'($urandom_range(1)));
      byp_out_vld = ($urandom_range(3) != 0);
      c2h_dsc_bypass = 2'($urandom());
      c2h_mm_marker_req = 1'($urandom_range(1));
      mm_rdy = ($urandom_range(3) != 0);
      csh_rdy = ($urandom_range(3) != 0);
      sim_rdy = ($urandom_range(3) != 0);
      step();
    end
    mm_rdy = 1'b1; csh_rdy = 1'b1; sim_rdy = 1'b1;
    idle(12);
    check("end_drained", 256'(q_mm.size() + q_csh.size() + q_sim.size()), 256'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
